// File: rtl/alu_op_sequencer.sv
// Serial loader and sequencer for the 8-bit ALU: operand A, operand B and the opcode
// arrive one per strobe on a shared pad bus, then the ALU result is registered and held.
module alu_op_sequencer #(
    parameter int WIDTH       = 8,
    parameter int SEL_W       = 2,
    parameter int SYNC_STAGES = 2,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] data_in,
    input  logic             stb,
    input  logic             abort,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_s,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] result_out,
    output logic             result_valid,
    output logic             busy,
    output logic [2:0]       phase
);

    localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] stb_sync;
    logic [SYNC_STAGES-1:0] abort_sync;
    logic                   stb_prev;
    logic                   ld;
    logic                   abort_s;
    logic [CNT_W-1:0]       cnt;
    logic                   cnt_zero;

    // Synchronisers run regardless of ena, so strobe edges seen while disabled are lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_sync   <= '0;
            abort_sync <= '0;
            stb_prev   <= 1'b0;
        end else begin
            stb_sync   <= {stb_sync[SYNC_STAGES-2:0], stb};
            abort_sync <= {abort_sync[SYNC_STAGES-2:0], abort};
            stb_prev   <= stb_sync[SYNC_STAGES-1];
        end
    end

    assign ld       = stb_sync[SYNC_STAGES-1] & ~stb_prev & ena;
    assign abort_s  = abort_sync[SYNC_STAGES-1];
    assign cnt_zero = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_A;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (ena) begin
            if (abort_s) begin
                state_nxt = WAIT_A;
            end else begin
                case (state)
                    WAIT_A:  if (ld) state_nxt = WAIT_B;
                    WAIT_B:  if (ld) state_nxt = WAIT_OP;
                    WAIT_OP: if (ld) state_nxt = EXEC;
                    EXEC:    if (cnt_zero) state_nxt = DONE;
                    DONE:    if (ld) state_nxt = WAIT_B;
                    default: state_nxt = WAIT_A;
                endcase
            end
        end
    end

    always_comb begin
        busy  = (state == EXEC);
        phase = state;
    end

    // Abort leaves operands and the last result in place; only validity and the counter drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a        <= '0;
            alu_b        <= '0;
            alu_s        <= '0;
            result_out   <= '0;
            result_valid <= 1'b0;
            cnt          <= '0;
        end else if (ena) begin
            if (abort_s) begin
                result_valid <= 1'b0;
                cnt          <= '0;
            end else begin
                case (state)
                    WAIT_A: begin
                        if (ld) alu_a <= data_in;
                    end
                    WAIT_B: begin
                        if (ld) alu_b <= data_in;
                    end
                    WAIT_OP: begin
                        if (ld) begin
                            alu_s <= data_in[SEL_W-1:0];
                            cnt   <= CNT_LOAD;
                        end
                    end
                    EXEC: begin
                        if (cnt_zero) begin
                            result_out   <= alu_result;
                            result_valid <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    DONE: begin
                        if (ld) begin
                            alu_a        <= data_in;
                            result_valid <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
